// File: rtl/step_sequencer.sv
// Drum step sequencer: NUM_CH x NUM_STEPS on/off pattern with a phase-accumulator tempo generator.
// Latency: trig/step_pos/bar_wrap are registered on the start edge or the step-tick edge; pattern writes apply on the next edge.
// Backpressure: none; free-running, and downstream sample players must accept every one-cycle trigger pulse.
module step_sequencer #(
    parameter int              NUM_CH         = 4,
    parameter int              NUM_STEPS      = 8,
    parameter int              BPM_W          = 8,
    parameter int              STEPS_PER_BEAT = 2,
    parameter longint unsigned TICK_LIMIT     = 64'd3000000000,
    localparam int             STEP_W         = $clog2(NUM_STEPS),
    localparam int             CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int             ACC_W          = $clog2(TICK_LIMIT) + 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play,
    input  logic [BPM_W-1:0]     bpm,
    input  logic [STEP_W-1:0]    len,
    input  logic [NUM_CH-1:0]    mute,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [NUM_STEPS-1:0] wr_row,
    output logic [NUM_CH-1:0]    trig,
    output logic [STEP_W-1:0]    step_pos,
    output logic                 playing,
    output logic                 bar_wrap
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0]  LIMIT     = ACC_W'(TICK_LIMIT);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    state_t               state;
    state_t               state_nxt;
    logic [NUM_STEPS-1:0] pattern [NUM_CH];

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_nxt;
    logic [ACC_W-1:0]     inc;
    logic [ACC_W-1:0]     acc_sum;
    logic [STEP_W-1:0]    len_q;
    logic [STEP_W-1:0]    len_nxt;
    logic [STEP_W-1:0]    len_clamped;
    logic [STEP_W-1:0]    pos_nxt;
    logic [NUM_CH-1:0]    column;
    logic [NUM_CH-1:0]    trig_nxt;
    logic                 trig_en;
    logic                 bar_nxt;
    logic                 tick;

    // Tempo increment is sized to the accumulator so bpm*STEPS_PER_BEAT never overflows.
    assign inc         = ACC_W'(bpm) * ACC_W'(STEPS_PER_BEAT);
    assign acc_sum     = acc + inc;
    assign len_clamped = ({1'b0, len} > (STEP_W + 1)'(NUM_STEPS - 1)) ? LAST_STEP : len;
    assign playing     = (state == ST_PLAY);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: play is a level, so both states simply follow it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: if (play)  state_nxt = ST_PLAY;
            ST_PLAY: if (!play) state_nxt = ST_STOP;
            default: state_nxt = ST_STOP;
        endcase
    end

    // Output/datapath next values: start loads step 0, ticks advance or wrap, stop clears everything.
    always_comb begin
        acc_nxt = '0;
        pos_nxt = '0;
        len_nxt = len_q;
        trig_en = 1'b0;
        bar_nxt = 1'b0;
        tick    = 1'b0;
        case (state)
            ST_STOP: begin
                if (play) begin
                    bar_nxt = 1'b1;
                    trig_en = 1'b1;
                    len_nxt = len_clamped;
                end
            end
            ST_PLAY: begin
                // When play drops, every default above (zeros) applies, dropping any coincident tick.
                if (play) begin
                    tick    = (acc_sum >= LIMIT);
                    acc_nxt = tick ? (acc_sum - LIMIT) : acc_sum;
                    pos_nxt = step_pos;
                    if (tick) begin
                        trig_en = 1'b1;
                        if (step_pos == len_q) begin
                            pos_nxt = '0;
                            bar_nxt = 1'b1;
                            len_nxt = len_clamped;
                        end else begin
                            pos_nxt = step_pos + STEP_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Column of the step being entered, read from the pre-write pattern contents.
    always_comb begin
        column = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            column[ch] = pattern[ch][pos_nxt];
        end
    end

    assign trig_nxt = trig_en ? (column & ~mute) : '0;

    // Registered outputs, accumulator and latched loop length.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            step_pos <= '0;
            trig     <= '0;
            bar_wrap <= 1'b0;
            len_q    <= '0;
        end else begin
            acc      <= acc_nxt;
            step_pos <= pos_nxt;
            trig     <= trig_nxt;
            bar_wrap <= bar_nxt;
            len_q    <= len_nxt;
        end
    end

    // Pattern memory: row writes in any state; out-of-range channel indices are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pattern[ch] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH))) begin
            pattern[wr_ch] <= wr_row;
        end
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Parametrised drum step sequencer: NUM_CH channels × NUM_STEPS steps of on/off pattern, with a tempo generator built in.
- Emits one-cycle trigger pulses per channel, which drive the sample players upstream of the mixer.
- Generalises the fixed 4×8 sequencer and bpm divider. Adds:
  - runtime loop length
  - per-channel mute
  - row writes while playing
  - fractional-accurate tempo through a phase accumulator

Parameters:
- NUM_CH, 4, number of instrument channels (1..16).
- NUM_STEPS, 8, steps per pattern (2..64). STEP_W = $clog2(NUM_STEPS).
- BPM_W, 8, width of bpm input.
- STEPS_PER_BEAT, 2, steps per quarter-note beat.
- TICK_LIMIT, 3000000000, clock frequency × 60 (50 MHz × 60). ACC_W = $clog2(TICK_LIMIT) + 2.

Ports:
- clk, in, 1, system clock (CLOCK_50).
- reset, in, 1, synchronous active-high reset.
- play, in, 1, level: 1 = run, 0 = stop.
- bpm, in, BPM_W, tempo in beats/min; sampled every cycle.
- len, in, STEP_W, index of last step in loop; sampled only at wrap/start.
- mute, in, NUM_CH, per-channel trigger mask (1 = suppress).
- wr_en, in, 1, pattern row write strobe.
- wr_ch, in, $clog2(NUM_CH) (min 1), channel row to write.
- wr_row, in, NUM_STEPS, new row; bit s = hit on step s.
- trig, out, NUM_CH, one-cycle hit pulses.
- step_pos, out, STEP_W, current step index.
- playing, out, 1, high in PLAY state.
- bar_wrap, out, 1, one-cycle pulse whenever step_pos is loaded with 0.

Behaviour:
- Reset:
  - All outputs 0; state STOP; accumulator 0.
  - Pattern memory cleared to all zeros; latched length = 0.
  - Reset overrides everything, including mid-play and a simultaneous wr_en.
- Pattern memory:
  - NUM_CH × NUM_STEPS flops.
  - wr_en writes wr_row into row wr_ch at the clock edge, in any state.
  - wr_ch ≥ NUM_CH: the write is ignored.
  - Triggers issued on the same edge as a write use the pre-write contents. The new row takes effect from the next step.
- FSM has two states, STOP and PLAY.
- STOP → PLAY (evaluated when play=1 in STOP, cycle N). At edge N:
  - state = PLAY, playing = 1, step_pos = 0, bar_wrap = 1.
  - trig = column0 & ~mute.
  - Accumulator cleared.
  - Latched length = min(len, NUM_STEPS−1).
- Tempo in PLAY, each cycle:
  - inc = bpm × STEPS_PER_BEAT, with ACC_W-bit arithmetic (no overflow).
  - If acc + inc ≥ TICK_LIMIT: acc ← acc + inc − TICK_LIMIT and a step tick occurs. Otherwise acc ← acc + inc.
  - bpm = 0 means no ticks. Position holds and the accumulator holds at its value.
- Step tick:
  - If step_pos == latched length: step_pos ← 0, bar_wrap = 1, and a new len is latched (clamped).
  - Otherwise step_pos ← step_pos + 1.
  - trig = column(new step_pos) & ~mute, registered on that same edge. trig is 0 on every non-tick cycle.
  - len changes take effect only at the wrap.
- Mute is applied at trigger time only. Unmuting does not replay a missed hit.
- PLAY → STOP when play=0. At that edge:
  - playing = 0, step_pos = 0, trig = 0, bar_wrap = 0, accumulator 0.
  - A tick coincident with stop is dropped.
- Restart always begins at step 0 with an immediate step-0 trigger.
- Step period = ceil-style average of TICK_LIMIT / inc cycles. Jitter is at most 1 cycle with no long-term drift.

Test Plan:
- TICK_LIMIT=60, STEPS_PER_BEAT=2, bpm=10 (inc 20); row0 = 8'b0000_0101, len=7; raise play:
  - Next cycle: trig[0]=1, step_pos=0, bar_wrap=1.
  - Ticks then occur every 3 cycles.
  - trig[0] pulses again at step 2 (cycle +6).
  - Wrap back to step 0 with bar_wrap at cycle +24.
- Same config with len=2 set mid-bar: loop continues to step 7, then cycles 0,1,2,0. bar_wrap repeats every 9 cycles.
- mute=4'b0001 with rows 0 and 1 = all ones: trig = 4'b0010 on every tick; trig[0] stays 0 throughout.
- wr_en to row 1 with 8'h08 on the same edge as the step-3 tick: no trig[1] at step 3 this bar; trig[1] fires at step 3 in the next bar.
- bpm=0 while playing: step_pos frozen and trig stays 0. Restoring bpm=10 resumes from the held position.
- reset asserted mid-play at step 5: next cycle all outputs 0 and the pattern is cleared. Replaying yields no triggers.
